rf_param_dump: RTL and testbench

- Parametrised register file; next generation of the CPU's 16x16 triple-ported RF.
- Provides 2 read ports and 1 write port. Data width and depth are configurable.
- Reads are registered, with optional write-to-read bypass. Register contents are cleared on reset.
- On halt, a handshaked dump engine streams every register out serially, so the bench or debug logic can capture final state without hierarchical peeks.

---
 rtl/rf_param_dump.sv | 129 ++++++++++++
 tb/tb_rf_param_dump.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_param_dump.sv
// rf_param_dump: parametrised 2R1W register file with a handshaked halt-time dump engine; RF_ZERO_REG_EN makes R0 a hard zero.
// Latency: reads are registered (1 cycle addr->data); the first dump beat appears 1 cycle after a hlt rising edge.
// Backpressure: a dump beat (addr/data) is held stable while dump_rdy=0; reads and writes never stall.
module rf_param_dump #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              re0,
    input  logic              re1,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] dst,
    input  logic              we,
    input  logic              hlt,
    input  logic              dump_rdy,
    output logic              dump_vld,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;
`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
`else
    localparam bit ZERO_REG = 1'b0;
    localparam logic [ADDR_W-1:0] FIRST = '0;
`endif

    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd0_val;
    logic [DATA_W-1:0] rd1_val;
    logic [ADDR_W-1:0] nxt_addr;
    logic              wr_ok;
    logic              hlt_q;
    logic              hlt_rise;
    state_t            state;

    // With a hard-zero R0 the write is dropped here, so bypass never forwards it either.
    assign wr_ok    = we && !(ZERO_REG && (dst_addr == '0));
    assign hlt_rise = hlt && !hlt_q;
    assign nxt_addr = dump_addr + 1'b1;

    always_comb begin
        rd0_val = mem[p0_addr];
        rd1_val = mem[p1_addr];
        if (BYPASS && wr_ok && (dst_addr == p0_addr)) rd0_val = dst;
        if (BYPASS && wr_ok && (dst_addr == p1_addr)) rd1_val = dst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[dst_addr] <= dst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0 <= '0;
            p1 <= '0;
        end else begin
            if (re0) p0 <= rd0_val;
            if (re1) p1 <= rd1_val;
        end
    end

    // dump_addr doubles as the beat index; dump_data samples pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hlt_q     <= 1'b0;
            dump_vld  <= 1'b0;
            dump_busy <= 1'b0;
            dump_done <= 1'b0;
            dump_addr <= '0;
            dump_data <= '0;
        end else begin
            hlt_q <= hlt;
            case (state)
                IDLE: begin
                    if (hlt_rise) begin
                        state     <= DUMP;
                        dump_vld  <= 1'b1;
                        dump_busy <= 1'b1;
                        dump_addr <= FIRST;
                        dump_data <= mem[FIRST];
                    end
                end
                DUMP: begin
                    if (dump_vld && dump_rdy) begin
                        if (dump_addr == LAST) begin
                            state     <= DONE;
                            dump_vld  <= 1'b0;
                            dump_busy <= 1'b0;
                            dump_done <= 1'b1;
                        end else begin
                            dump_addr <= nxt_addr;
                            dump_data <= mem[nxt_addr];
                        end
                    end
                end
                DONE: begin
                    if (!hlt) begin
                        state     <= IDLE;
                        dump_done <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    dump_vld  <= 1'b0;
                    dump_busy <= 1'b0;
                    dump_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rf_param_dump.sv
// Self-checking bench for rf_param_dump: a bypassing and a non-bypassing instance share stimulus
// and are compared each cycle against a behavioural register-file and dump model.
module tb_rf_param_dump;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 16;
`ifdef RF_ZERO_REG_EN
    localparam bit ZR = 1'b1;
    localparam int FIRST = 1;
`else
    localparam bit ZR = 1'b0;
    localparam int FIRST = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] p0_addr, p1_addr, dst_addr;
    logic          re0, re1, we, hlt, dump_rdy;
    logic [DW-1:0] dst;
    logic [DW-1:0] p0, p1, dump_data, nb_p0, nb_p1, nb_dump_data;
    logic [AW-1:0] dump_addr, nb_dump_addr;
    logic          dump_vld, dump_busy, dump_done, nb_dump_vld, nb_dump_busy, nb_dump_done;

    always #5 clk = ~clk;

    rf_param_dump #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
        .p0(p0), .p1(p1), .dst_addr(dst_addr), .dst(dst), .we(we), .hlt(hlt),
        .dump_rdy(dump_rdy), .dump_vld(dump_vld), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done));

    rf_param_dump #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
        .p0(nb_p0), .p1(nb_p1), .dst_addr(dst_addr), .dst(dst), .we(we), .hlt(hlt),
        .dump_rdy(dump_rdy), .dump_vld(nb_dump_vld), .dump_addr(nb_dump_addr),
        .dump_data(nb_dump_data), .dump_busy(nb_dump_busy), .dump_done(nb_dump_done));

    int vectors = 0;
    int miscompares = 0;
    int beats = 0;

    // Reference model: register contents, expected read outputs, dump progress.
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] e_p0, e_p1, e_p0_nb, e_p1_nb, m_ddata;
    bit            m_active, m_done, m_hq;
    int            m_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        e_p0 = '0; e_p1 = '0; e_p0_nb = '0; e_p1_nb = '0; m_ddata = '0;
        m_active = 1'b0; m_done = 1'b0; m_hq = 1'b0; m_idx = 0;
    endtask

    task automatic compare_all();
        check("p0", p0, e_p0);
        check("p1", p1, e_p1);
        check("p0_nobypass", nb_p0, e_p0_nb);
        check("p1_nobypass", nb_p1, e_p1_nb);
        check("dump_vld", dump_vld, m_active);
        check("dump_busy", dump_busy, m_active);
        check("dump_done", dump_done, m_done);
        check("nb_dump_vld", nb_dump_vld, m_active);
        check("nb_dump_busy", nb_dump_busy, m_active);
        check("nb_dump_done", nb_dump_done, m_done);
        if (m_active) begin
            check("dump_addr", dump_addr, m_idx);
            check("dump_data", dump_data, m_ddata);
            check("nb_dump_addr", nb_dump_addr, m_idx);
            check("nb_dump_data", nb_dump_data, m_ddata);
        end
    endtask

    // Apply the effect of the coming clock edge to the model, then step and compare.
    task automatic tick();
        logic wok;
        wok = we && !(ZR && dst_addr == 0);
        if (dump_vld && dump_rdy) beats++;
        if (re0) begin
            e_p0_nb = mm[p0_addr];
            e_p0 = (wok && dst_addr == p0_addr) ? dst : mm[p0_addr];
        end
        if (re1) begin
            e_p1_nb = mm[p1_addr];
            e_p1 = (wok && dst_addr == p1_addr) ? dst : mm[p1_addr];
        end
        if (m_active) begin
            if (dump_rdy) begin
                if (m_idx == DEPTH - 1) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_idx++;
                    m_ddata = mm[m_idx];
                end
            end
        end else if (m_done) begin
            if (!hlt) m_done = 1'b0;
        end else if (hlt && !m_hq) begin
            m_active = 1'b1;
            m_idx = FIRST;
            m_ddata = mm[FIRST];
        end
        m_hq = hlt;
        if (wok) mm[dst_addr] = dst;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic [DW-1:0] r2;
        bit hit;
        rst = 1'b1; we = 0; re0 = 0; re1 = 0; hlt = 0; dump_rdy = 0;
        p0_addr = 0; p1_addr = 0; dst_addr = 0; dst = 0;
        model_reset();
        #3;
        check("rst_p0", p0, 0);
        check("rst_p1", p1, 0);
        check("rst_dump_vld", dump_vld, 0);
        check("rst_dump_busy", dump_busy, 0);
        check("rst_dump_done", dump_done, 0);
        check("rst_dump_addr", dump_addr, 0);
        check("rst_dump_data", dump_data, 0);
        #4;
        rst = 1'b0;

        // Write R3, read it back, read never-written R5.
        we = 1; dst_addr = 3; dst = 16'hBEEF; tick();
        we = 0; re0 = 1; p0_addr = 3; tick();
        check("read_r3", p0, 16'hBEEF);
        p0_addr = 5; tick();
        check("read_r5", p0, 16'h0000);

        // Write and read R7 in the same cycle.
        re0 = 0; we = 1; dst_addr = 7; dst = 16'h1234; re1 = 1; p1_addr = 7; tick();
        check("bypass_r7", p1, 16'h1234);
        check("nobypass_r7", nb_p1, 16'h0000);
        we = 0; re1 = 0;

        // re0 low: p0 holds while its address wanders.
        for (int i = 0; i < 3; i++) begin
            p0_addr = AW'($urandom); tick();
            check("p0_hold", p0, 16'h0000);
        end

        // Both ports read R2 together.
        r2 = DW'($urandom);
        we = 1; dst_addr = 2; dst = r2; tick();
        we = 0; re0 = 1; re1 = 1; p0_addr = 2; p1_addr = 2; tick();
        check("dual_read_r2", p0, r2);
        check("dual_read_eq", p1, p0);

        // Write R0 while reading it.
        we = 1; dst_addr = 0; dst = 16'hFFFF; p0_addr = 0; tick();
        check("r0_write_read", p0, ZR ? 32'h0 : 32'hFFFF);
        we = 0; tick();
        check("r0_later_read", p0, ZR ? 32'h0 : 32'hFFFF);

        // Random traffic with occasional halts and random consumer readiness.
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom); re0 = 1'($urandom); re1 = 1'($urandom);
            dst_addr = AW'($urandom); dst = DW'($urandom);
            p0_addr = ($urandom_range(0, 3) == 0) ? dst_addr : AW'($urandom);
            p1_addr = AW'($urandom);
            hlt = ($urandom_range(0, 15) == 0);
            dump_rdy = 1'($urandom);
            tick();
        end
        we = 0; re0 = 0; re1 = 0; hlt = 0; dump_rdy = 1;
        for (int i = 0; i < 20; i++) tick();

        // Full dump with the consumer always ready.
        for (int n = 0; n < DEPTH; n++) begin
            we = 1; dst_addr = AW'(n); dst = DW'(n * 16'h0101); tick();
        end
        we = 0; hlt = 1; beats = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i < DEPTH - FIRST) begin
                check("beat_addr", dump_addr, FIRST + i);
                check("beat_data", dump_data, (FIRST + i) * 16'h0101);
            end
        end
        check("beat_count", beats, DEPTH - FIRST);
        check("done_while_hlt", dump_done, 1);
        hlt = 0; tick();
        check("idle_done", dump_done, 0);
        check("idle_busy", dump_busy, 0);

        // Stalled dump with writes to the held index, then reset after 5 beats.
        for (int n = 0; n < DEPTH; n++) begin
            we = 1; dst_addr = AW'(n); dst = DW'($urandom); tick();
        end
        we = 0; hlt = 1; beats = 0; tick();
        hlt = 0; hit = 0;
        for (int k = 0; k < 60 && !hit; k++) begin
            dump_rdy = (k % 4 == 0) || (k % 4 == 3);
            we = !dump_rdy; dst_addr = AW'(m_idx); dst = DW'($urandom);
            tick();
            if (beats == 5) hit = 1;
        end
        check("beat5_reached", hit, 1);
        we = 0; dump_rdy = 1;
        rst = 1'b1;
        #1;
        model_reset();
        check("abort_dump_vld", dump_vld, 0);
        check("abort_dump_busy", dump_busy, 0);
        check("abort_dump_done", dump_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
        beats = 0;
        for (int i = 0; i < 4; i++) tick();
        check("no_beats_after_abort", beats, 0);

        // Post-reset dump on a one-cycle hlt pulse: all registers cleared.
        hlt = 1; beats = 0; tick();
        hlt = 0;
        for (int i = 0; i < 80; i++) begin
            dump_rdy = 1'($urandom);
            tick();
        end
        check("final_beat_count", beats, DEPTH - FIRST);
        check("final_busy", dump_busy, 0);
        check("final_done", dump_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
